// File: rtl/chrom_eval_sequencer.sv
// Chromosome-evaluation sequencer: holds chromosome segments and a test-vector bank, runs each
// vector through the genetic circuit and keeps saturating per-output-bit error sums.
// Optional feature macro: CHROM_EVAL_HARDCODED_INPUT_EN (hardcoded circuit-input override in IDLE).
module chrom_eval_sequencer #(
    parameter int NUM_SEGS      = 31,
    parameter int SEG_WIDTH     = 32,
    parameter int IN_WIDTH      = 8,
    parameter int OUT_WIDTH     = 8,
    parameter int MAX_SEQS      = 256,
    parameter int ERR_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                            iClock,
    input  logic                            iReset_n,
    input  logic                            iSegWrite,
    input  logic [$clog2(NUM_SEGS)-1:0]     iSegAddr,
    input  logic [SEG_WIDTH-1:0]            iSegData,
    input  logic                            iVecWrite,
    input  logic [$clog2(MAX_SEQS)-1:0]     iVecAddr,
    input  logic [IN_WIDTH-1:0]             iVecInput,
    input  logic [OUT_WIDTH-1:0]            iVecExpected,
    input  logic [OUT_WIDTH-1:0]            iVecValid,
    input  logic [$clog2(MAX_SEQS):0]       iSequencesToProcess,
    input  logic                            iStartProcessing,
    input  logic                            iDoneProcessingFeedback,
    input  logic                            iStall,
    output logic                            oReadyToProcess,
    output logic                            oDoneProcessing,
    output logic [NUM_SEGS*SEG_WIDTH-1:0]   oChromDescription,
    output logic [IN_WIDTH-1:0]             oCircuitInput,
    input  logic [OUT_WIDTH-1:0]            iCircuitOutput,
    output logic [OUT_WIDTH*ERR_WIDTH-1:0]  oErrorSums,
`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
    input  logic [IN_WIDTH-1:0]             iHardCodedInput,
    input  logic                            iUseHardcodedInput,
`endif
    output logic [1:0]                      oState
);

    localparam int VEC_AW = $clog2(MAX_SEQS);
    localparam int CNT_W  = VEC_AW + 1;
    localparam int STL_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int VEC_W  = IN_WIDTH + 2 * OUT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic                   ack_seen;
    logic                   ack_nx;
    logic                   ready_r;
    logic                   ready_nx;
    logic                   done_r;
    logic                   done_nx;
    logic                   running;
    logic                   use_hc;
    logic                   start_ok;
    logic                   settle_end;
    logic                   last_vec;
    logic [STL_W-1:0]       settle_cnt;
    logic [VEC_AW-1:0]      index;
    logic [VEC_AW-1:0]      rd_addr;
    logic [CNT_W-1:0]       num_vecs;
    logic [SEG_WIDTH-1:0]   segs [NUM_SEGS];
    logic [ERR_WIDTH-1:0]   sums [OUT_WIDTH];
    logic [VEC_W-1:0]       vec_mem [MAX_SEQS];
    logic [VEC_W-1:0]       vec_rd;
    logic [IN_WIDTH-1:0]    vec_in;
    logic [IN_WIDTH-1:0]    circ_in;
    logic [IN_WIDTH-1:0]    idle_in;
    logic [OUT_WIDTH-1:0]   vec_exp;
    logic [OUT_WIDTH-1:0]   vec_val;
    logic [OUT_WIDTH-1:0]   miss;

    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_WIDTH'(1);
    endfunction

    function automatic logic [CNT_W-1:0] clamp_n(input logic [CNT_W-1:0] n);
        return (n > CNT_W'(MAX_SEQS)) ? CNT_W'(MAX_SEQS) : n;
    endfunction

`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
    assign use_hc  = iUseHardcodedInput;
    assign idle_in = (state == IDLE && iUseHardcodedInput) ? iHardCodedInput : '0;
`else
    assign use_hc  = 1'b0;
    assign idle_in = '0;
`endif

    assign {vec_in, vec_exp, vec_val} = vec_rd;
    assign miss       = vec_val & (iCircuitOutput ^ vec_exp);
    assign start_ok   = iStartProcessing && !use_hc;
    assign settle_end = (settle_cnt == STL_W'(SETTLE_CYCLES - 1));
    assign last_vec   = ({1'b0, index} == num_vecs - CNT_W'(1));

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state    <= IDLE;
            ack_seen <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            state    <= state_nx;
            ack_seen <= ack_nx && (state_nx == DONE);
            ready_r  <= ready_nx;
            done_r   <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = (iSequencesToProcess == '0) ? DONE : SETTLE;
            SETTLE:  if (!iStall && settle_end) state_nx = SAMPLE;
            SAMPLE:  if (!iStall) state_nx = last_vec ? DONE : SETTLE;
            DONE:    if (ack_seen && !iDoneProcessingFeedback) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Done drops as soon as feedback is seen; the RAM address runs one vector ahead during SAMPLE.
    always_comb begin
        ack_nx   = (state == DONE) && (ack_seen || iDoneProcessingFeedback);
        ready_nx = (state_nx == IDLE) && !use_hc;
        done_nx  = (state_nx == DONE) && !ack_nx;
        running  = (state_nx == SETTLE) || (state_nx == SAMPLE);
        rd_addr  = index;
        if (state == IDLE)
            rd_addr = '0;
        else if (state == SAMPLE && !iStall)
            rd_addr = index + VEC_AW'(1);
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            settle_cnt <= '0;
            index      <= '0;
            num_vecs   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    settle_cnt <= '0;
                    if (start_ok) begin
                        index    <= '0;
                        num_vecs <= clamp_n(iSequencesToProcess);
                    end
                end
                SETTLE: if (!iStall) settle_cnt <= settle_end ? '0 : settle_cnt + STL_W'(1);
                SAMPLE: if (!iStall) index <= index + VEC_AW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int b = 0; b < OUT_WIDTH; b++) sums[b] <= '0;
        end else if (state == IDLE && start_ok) begin
            for (int b = 0; b < OUT_WIDTH; b++) sums[b] <= '0;
        end else if (state == SAMPLE && !iStall) begin
            for (int b = 0; b < OUT_WIDTH; b++)
                if (miss[b]) sums[b] <= sat_inc(sums[b]);
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int k = 0; k < NUM_SEGS; k++) segs[k] <= '0;
        end else if (state == IDLE && iSegWrite && int'(iSegAddr) < NUM_SEGS) begin
            segs[iSegAddr] <= iSegData;
        end
    end

    // Vector bank is a plain synchronous RAM so it maps onto block memory.
    always_ff @(posedge iClock) begin
        if (state == IDLE && iVecWrite)
            vec_mem[iVecAddr] <= {iVecInput, iVecExpected, iVecValid};
        vec_rd <= vec_mem[rd_addr];
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            circ_in <= '0;
        end else if (running) begin
            if (state == SETTLE) circ_in <= vec_in;
        end else begin
            circ_in <= idle_in;
        end
    end

    assign oState          = state;
    assign oReadyToProcess = ready_r;
    assign oDoneProcessing = done_r;
    assign oCircuitInput   = circ_in;

    for (genvar g = 0; g < NUM_SEGS; g++) begin : g_chrom
        assign oChromDescription[g*SEG_WIDTH +: SEG_WIDTH] = segs[g];
    end

    for (genvar g = 0; g < OUT_WIDTH; g++) begin : g_sums
        assign oErrorSums[g*ERR_WIDTH +: ERR_WIDTH] = sums[g];
    end

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Bench for chrom_eval_sequencer: table of directed/random runs checked against a per-vector
// error-count model, plus reset, loading, handshake and mid-run reset sequences.
`timescale 1ns/1ps
module tb_chrom_eval_sequencer;
    localparam int NS = 31, SW = 32, IW = 8, OW = 8, MS = 256, SC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, seg_wr, vec_wr, start, fb, stall;
    logic [4:0] seg_addr;
    logic [31:0] seg_data;
    logic [7:0] vec_addr, vin, vexp, vval;
    logic [8:0] seqs;
    logic ready1, done1, ready2, done2;
    logic [NS*SW-1:0] chrom1, chrom2;
    logic [7:0] cin1, cin2, cout1, cout2;
    logic [OW*32-1:0] sums1;
    logic [OW*2-1:0] sums2;
    logic [1:0] state1, state2;
`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
    logic [7:0] hc_val;
    logic use_hc;
`endif

    logic [7:0] lut [256];
    assign cout1 = lut[cin1];
    assign cout2 = lut[cin2];

    chrom_eval_sequencer #(.SETTLE_CYCLES(SC)) dut (
        .iClock(clk), .iReset_n(rst_n), .iSegWrite(seg_wr), .iSegAddr(seg_addr), .iSegData(seg_data),
        .iVecWrite(vec_wr), .iVecAddr(vec_addr), .iVecInput(vin), .iVecExpected(vexp), .iVecValid(vval),
        .iSequencesToProcess(seqs), .iStartProcessing(start), .iDoneProcessingFeedback(fb), .iStall(stall),
        .oReadyToProcess(ready1), .oDoneProcessing(done1), .oChromDescription(chrom1),
        .oCircuitInput(cin1), .iCircuitOutput(cout1), .oErrorSums(sums1),
`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
        .iHardCodedInput(hc_val), .iUseHardcodedInput(use_hc),
`endif
        .oState(state1));

    chrom_eval_sequencer #(.SETTLE_CYCLES(SC), .ERR_WIDTH(2)) dut2 (
        .iClock(clk), .iReset_n(rst_n), .iSegWrite(seg_wr), .iSegAddr(seg_addr), .iSegData(seg_data),
        .iVecWrite(vec_wr), .iVecAddr(vec_addr), .iVecInput(vin), .iVecExpected(vexp), .iVecValid(vval),
        .iSequencesToProcess(seqs), .iStartProcessing(start), .iDoneProcessingFeedback(fb), .iStall(stall),
        .oReadyToProcess(ready2), .oDoneProcessing(done2), .oChromDescription(chrom2),
        .oCircuitInput(cin2), .iCircuitOutput(cout2), .oErrorSums(sums2),
`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
        .iHardCodedInput(hc_val), .iUseHardcodedInput(use_hc),
`endif
        .oState(state2));

    int errors = 0;
    int checks = 0;
    logic [7:0] m_in [256], m_exp [256], m_val [256];
    logic [NS*SW-1:0] m_chrom;

    typedef struct {
        int n; int mode; logic [7:0] mask; bit rnd_val;
        int stall_pct; int stall_at; bit poke; bit hold_start; int exp_base;
    } run_t;
    run_t runs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_chrom(input string name);
        checks++;
        if (chrom1 !== m_chrom) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, chrom1, m_chrom);
        end
    endtask

    task automatic load_vectors(input int n, input int mode, input bit rnd_val, input logic [7:0] mask);
        for (int i = 0; i < n; i++) begin
            m_in[i] = 8'($urandom);
            m_val[i] = rnd_val ? 8'($urandom) : mask;
            case (mode)
                0: m_exp[i] = lut[m_in[i]];
                1: m_exp[i] = ~lut[m_in[i]];
                default: m_exp[i] = 8'($urandom);
            endcase
            @(negedge clk);
            vec_wr = 1'b1; vec_addr = 8'(i); vin = m_in[i]; vexp = m_exp[i]; vval = m_val[i];
        end
        @(negedge clk);
        vec_wr = 1'b0;
    endtask

    task automatic run_one(input run_t r);
        int n_eff, cyc, stalls, k, e2;
        int cnt [OW];
        bit got, st;
        logic [7:0] pin;
        n_eff = (r.n > MS) ? MS : r.n;
        load_vectors(n_eff, r.mode, r.rnd_val, r.mask);
        for (int b = 0; b < OW; b++) begin
            cnt[b] = 0;
            for (int i = 0; i < n_eff; i++) begin
                pin = lut[m_in[i]];
                if (m_val[i][b] && (pin[b] != m_exp[i][b])) cnt[b]++;
            end
        end
        @(negedge clk);
        seqs = 9'(r.n); start = 1'b1;
        cyc = 0; stalls = 0; k = 0; got = 1'b0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            seg_wr = 1'b0; vec_wr = 1'b0;
            if (!r.hold_start) start = 1'b0;
            if (done1) begin
                got = 1'b1;
            end else begin
                if (cyc == 1) check("ready_low_cycle1", ready1, 0);
                if (state1 == 2'd2 && k < n_eff) check("cin_in_sample", cin1, m_in[k]);
                if (r.poke && cyc == 2) begin
                    seg_wr = 1'b1; seg_addr = 5'd5; seg_data = 32'hDEAD_BEEF;
                    vec_wr = 1'b1; vec_addr = 8'(n_eff - 1); vin = 8'($urandom);
                    vexp = lut[vin]; vval = 8'hFF;
                end
                st = 1'b0;
                if (state1 == 2'd1 || state1 == 2'd2) begin
                    if (r.stall_at != 0 && cyc >= r.stall_at && cyc < r.stall_at + 5) st = 1'b1;
                    if (r.stall_pct > 0 && $urandom_range(99) < r.stall_pct) st = 1'b1;
                end
                stall = st;
                if (st) stalls++;
                if (state1 == 2'd2 && !st) k++;
            end
        end
        stall = 1'b0; start = 1'b0; seg_wr = 1'b0; vec_wr = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done at %0d", cyc, r.exp_base + stalls);
        end
        check("done_cycle", cyc, r.exp_base + stalls);
        check("sample_count", k, n_eff);
        check("state_done", state1, 3);
        check("dut2_done", done2, 1);
        check("cin_zero_done", cin1, 0);
        for (int b = 0; b < OW; b++) begin
            e2 = (cnt[b] > 3) ? 3 : cnt[b];
            check($sformatf("sum32_bit%0d", b), sums1[b*32 +: 32], cnt[b]);
            check($sformatf("sum2_bit%0d", b), sums2[b*2 +: 2], e2);
        end
        check_chrom("chrom_after_run");
        fb = 1'b1;
        @(negedge clk);
        check("done_drop", done1, 0);
        repeat (2) begin
            @(negedge clk);
            check("hold_in_done", state1, 3);
            check("done_stays_low", done1, 0);
        end
        fb = 1'b0;
        @(negedge clk);
        check("back_to_idle", state1, 0);
        check("ready_idle", ready1, 1);
    endtask

    initial begin
        rst_n = 1'b1; seg_wr = 0; vec_wr = 0; start = 0; fb = 0; stall = 0;
        seg_addr = '0; seg_data = '0; vec_addr = '0; vin = '0; vexp = '0; vval = '0; seqs = '0;
`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
        hc_val = '0; use_hc = 1'b0;
`endif
        for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
        m_chrom = '0;
        runs[0] = '{n:4,   mode:0, mask:8'hFF, rnd_val:0, stall_pct:0,  stall_at:0, poke:0, hold_start:0, exp_base:21};
        runs[1] = '{n:3,   mode:1, mask:8'h0F, rnd_val:0, stall_pct:0,  stall_at:0, poke:1, hold_start:0, exp_base:16};
        runs[2] = '{n:0,   mode:0, mask:8'hFF, rnd_val:0, stall_pct:0,  stall_at:0, poke:0, hold_start:0, exp_base:1};
        runs[3] = '{n:20,  mode:2, mask:8'h00, rnd_val:1, stall_pct:20, stall_at:0, poke:0, hold_start:0, exp_base:101};
        runs[4] = '{n:300, mode:2, mask:8'h00, rnd_val:1, stall_pct:0,  stall_at:0, poke:0, hold_start:0, exp_base:1281};
        runs[5] = '{n:5,   mode:1, mask:8'hFF, rnd_val:0, stall_pct:0,  stall_at:0, poke:0, hold_start:1, exp_base:26};
        runs[6] = '{n:4,   mode:2, mask:8'h00, rnd_val:1, stall_pct:0,  stall_at:2, poke:0, hold_start:0, exp_base:21};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", state1, 0);
        check("rst_ready", ready1, 1);
        check("rst_done", done1, 0);
        check("rst_cin", cin1, 0);
        check("rst_sums", sums1[63:0], 0);
        check("rst_sums_hi", sums1[255:192], 0);
        check_chrom("rst_chrom");

        for (int k = 0; k < NS + 1; k++) begin
            @(negedge clk);
            seg_wr = 1'b1; seg_addr = 5'(k);
            seg_data = (k < NS) ? 32'h1000_0000 + 32'(k) : 32'hFFFF_FFFF;
            if (k < NS) m_chrom[k*SW +: SW] = seg_data;
        end
        @(negedge clk);
        seg_wr = 1'b0;
        @(negedge clk);
        check_chrom("seg_load");

        for (int i = 0; i < 7; i++) run_one(runs[i]);

`ifdef CHROM_EVAL_HARDCODED_INPUT_EN
        @(negedge clk);
        use_hc = 1'b1; hc_val = 8'hA5;
        @(negedge clk);
        check("hc_cin", cin1, 8'hA5);
        check("hc_ready", ready1, 0);
        seqs = 9'd4; start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hc_start_ignored", state1, 0);
        end
        start = 1'b0; use_hc = 1'b0; hc_val = '0;
        repeat (2) @(negedge clk);
        check("hc_off_cin", cin1, 0);
        check("hc_off_ready", ready1, 1);
`endif

        load_vectors(10, 1, 1'b0, 8'hFF);
        @(negedge clk);
        seqs = 9'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (sums1[31:0] == 32'd0) begin
            errors++;
            $display("FAIL midrun_sums_nonzero: got %0h expected nonzero", sums1[31:0]);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_state", state1, 0);
        check("midrst_ready", ready1, 1);
        check("midrst_done", done1, 0);
        check("midrst_sums", sums1[63:0], 0);
        m_chrom = '0;
        check_chrom("midrst_chrom");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_one(runs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
